// File: rtl/multi_filter_select_pkg.sv
// Shared types and helpers for the multi-filter pixel pipeline.
// Holds the filter-code enum, pixel/channel widths and the per-pixel filter function.
package multi_filter_select_pkg;

    localparam int PIX_W = 12;
    localparam int CH_W  = 4;

    typedef enum logic [1:0] {
        FILT_PASS   = 2'b00,
        FILT_GRAY   = 2'b01,
        FILT_INV    = 2'b10,
        FILT_THRESH = 2'b11
    } filt_e;

    // Six bits hold the worst case 15 + 30 + 15 = 60 before the divide by four.
    function automatic logic [CH_W-1:0] luma(input logic [PIX_W-1:0] p);
        logic [5:0] sum;
        sum = {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
        return sum[5:2];
    endfunction

    function automatic logic [PIX_W-1:0] apply_filter(input logic [PIX_W-1:0] p,
                                                      input filt_e           f,
                                                      input logic [CH_W-1:0] thresh);
        logic [CH_W-1:0]  y;
        logic [PIX_W-1:0] res;
        y = luma(p);
        unique case (f)
            FILT_PASS:   res = p;
            FILT_GRAY:   res = {y, y, y};
            FILT_INV:    res = ~p;
            FILT_THRESH: res = (y >= thresh) ? 12'hFFF : 12'h000;
            default:     res = p;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multi_filter_select_if.sv
// Pixel stream handshake between upstream source, the filter block and downstream sink.
// The slave modport is the filter block's view; master is the environment driving it.
interface multi_filter_select_if;
    import multi_filter_select_pkg::*;

    logic [PIX_W-1:0] pixel_in;
    logic             valid_in;
    logic             ready_in;
    logic [PIX_W-1:0] pixel_out;
    logic             valid_out;
    logic             ready_out;

    modport slave (
        input  pixel_in,
        input  valid_in,
        output ready_in,
        output pixel_out,
        output valid_out,
        input  ready_out
    );

    modport master (
        output pixel_in,
        output valid_in,
        input  ready_in,
        input  pixel_out,
        input  valid_out,
        output ready_out
    );

endinterface

// File: rtl/multi_filter_select_filter_fsm.sv
// Debounces the asynchronous filter request: a new code must be seen on
// DELAY_COUNTS consecutive edges before it becomes the active filter.
module filter_fsm
    import multi_filter_select_pkg::*;
#(
    parameter int DELAY_COUNTS = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic [1:0] filter_active
);

    localparam int            CW       = $clog2(DELAY_COUNTS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_COUNTS - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } sel_state_e;

    sel_state_e    fsm_q,    fsm_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    filt_e         cand_q,   cand_d;
    filt_e         active_q, active_d;
    filt_e         req;

    assign req           = filt_e'(state);
    assign filter_active = active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= STABLE;
            cnt_q    <= '0;
            cand_q   <= FILT_PASS;
            active_q <= FILT_PASS;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            active_q <= active_d;
        end
    end

    // Returning to the active code wins over re-arming on a new candidate.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        active_d = active_q;
        unique case (fsm_q)
            STABLE: begin
                if (req != active_q) begin
                    if (DELAY_COUNTS == 1) begin
                        active_d = req;
                        cnt_d    = '0;
                    end else begin
                        fsm_d  = PENDING;
                        cnt_d  = CW'(1);
                        cand_d = req;
                    end
                end
            end
            PENDING: begin
                if (req == active_q) begin
                    fsm_d = STABLE;
                    cnt_d = '0;
                end else if (req != cand_q) begin
                    cand_d = req;
                    cnt_d  = CW'(1);
                end else if (cnt_q >= CNT_LAST) begin
                    active_d = cand_q;
                    fsm_d    = STABLE;
                    cnt_d    = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                fsm_d = STABLE;
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_filter_select.sv
// RGB444 filter stage with debounced filter selection and a one-deep
// registered output that supports full-throughput ready/valid streaming.
module multi_filter_select
    import multi_filter_select_pkg::*;
#(
    parameter int          DELAY_COUNTS = 2500,
    parameter int unsigned THRESH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             state,
    output logic [1:0]             filter_active,
    multi_filter_select_if.slave   px
);

    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             valid_q, valid_d;
    logic             accept;

    filter_fsm #(
        .DELAY_COUNTS (DELAY_COUNTS)
    ) u_filter_fsm (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .filter_active (filter_active)
    );

    assign px.ready_in  = px.ready_out || !valid_q;
    assign accept       = px.valid_in && px.ready_in;
    assign px.pixel_out = pixel_q;
    assign px.valid_out = valid_q;

    // Filter uses the code active before this edge, so a same-edge change hits the next pixel.
    always_comb begin
        pixel_d = pixel_q;
        valid_d = valid_q;
        if (accept) begin
            pixel_d = apply_filter(px.pixel_in, filt_e'(filter_active), CH_W'(THRESH));
            valid_d = 1'b1;
        end else if (px.ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_multi_filter_select.sv
// Directed bench for multi_filter_select: a run-length/queue reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_multi_filter_select;

    localparam int DELAY  = 2;
    localparam int THRESH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic [1:0]  filter_active;

    int n_checks = 0;
    int n_errors = 0;

    multi_filter_select_if pif ();

    multi_filter_select #(
        .DELAY_COUNTS (DELAY),
        .THRESH       (THRESH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .filter_active (filter_active),
        .px            (pif)
    );

    always #5 clk = ~clk;

    // Reference model: selection as a run length of identical requests,
    // output stage as an ordered queue of pixels still owed downstream.
    int          m_active  = 0;
    int          m_run_val = 0;
    int          m_run_len = 0;
    logic [11:0] m_q[$];
    logic [11:0] delivered[$];
    bit          chk_en = 1'b0;
    bit          log_en = 1'b0;

    function automatic logic [11:0] model_filter(input logic [11:0] p, input int f);
        int r, g, b, y;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        y = (r + 2 * g + b) / 4;
        case (f)
            0:       return p;
            1:       return {y[3:0], y[3:0], y[3:0]};
            2:       begin
                         r = 15 - r; g = 15 - g; b = 15 - b;
                         return {r[3:0], g[3:0], b[3:0]};
                     end
            default: return (y >= THRESH) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: capture inputs, advance the model across the edge, return 1 after it.
    task automatic applyStimulus();
        logic        c_rst, c_vin, c_rdy;
        logic [1:0]  c_st;
        logic [11:0] c_pix;
        bit          can_take;
        c_rst = reset;
        c_vin = pif.valid_in;
        c_rdy = pif.ready_out;
        c_st  = state;
        c_pix = pif.pixel_in;
        @(posedge clk);
        if (c_rst) begin
            m_q.delete();
            m_active  = 0;
            m_run_len = 0;
        end else begin
            can_take = c_rdy || (m_q.size() == 0);
            if (m_q.size() > 0 && c_rdy) void'(m_q.pop_front());
            if (c_vin && can_take) m_q.push_back(model_filter(c_pix, m_active));
            if (int'(c_st) == m_active) begin
                m_run_len = 0;
            end else if (m_run_len > 0 && int'(c_st) == m_run_val) begin
                m_run_len++;
            end else begin
                m_run_val = int'(c_st);
                m_run_len = 1;
            end
            if (m_run_len >= DELAY) begin
                m_active  = m_run_val;
                m_run_len = 0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("filter_active", {10'd0, filter_active}, 12'(m_active));
            checkOutput("ready_in", {11'd0, pif.ready_in}, {11'd0, (pif.ready_out || m_q.size() == 0)});
            if (m_q.size() > 0) begin
                checkOutput("valid_out", {11'd0, pif.valid_out}, 12'd1);
                checkOutput("pixel_out", pif.pixel_out, m_q[0]);
            end else begin
                checkOutput("valid_out", {11'd0, pif.valid_out}, 12'd0);
            end
            if (log_en && pif.valid_out && pif.ready_out) delivered.push_back(pif.pixel_out);
        end
    end

    initial begin
        reset         = 1'b1;
        state         = 2'b00;
        pif.valid_in  = 1'b0;
        pif.pixel_in  = 12'h000;
        pif.ready_out = 1'b1;
        applyStimulus();
        applyStimulus();
        chk_en = 1'b1;
        checkOutput("rst_active", {10'd0, filter_active}, 12'd0);
        checkOutput("rst_valid", {11'd0, pif.valid_out}, 12'd0);
        checkOutput("rst_pixel", pif.pixel_out, 12'h000);
        reset = 1'b0;

        // Grayscale after two stable edges; (4 + 2*10 + 2) >> 2 = 6.
        state = 2'b01;
        applyStimulus();
        checkOutput("gray_one_edge", {10'd0, filter_active}, 12'd0);
        applyStimulus();
        checkOutput("gray_two_edges", {10'd0, filter_active}, 12'd1);
        pif.valid_in = 1'b1; pif.pixel_in = 12'h4A2;
        applyStimulus();
        pif.valid_in = 1'b0;
        checkOutput("gray_4A2", pif.pixel_out, 12'h666);

        // One-edge glitch to threshold is ignored.
        state = 2'b11;
        applyStimulus();
        state = 2'b01;
        applyStimulus();
        applyStimulus();
        checkOutput("glitch_ignored", {10'd0, filter_active}, 12'd1);

        state = 2'b10;
        applyStimulus();
        applyStimulus();
        checkOutput("inv_active", {10'd0, filter_active}, 12'd2);
        pif.valid_in = 1'b1; pif.pixel_in = 12'h4A2;
        applyStimulus();
        pif.valid_in = 1'b0;
        checkOutput("inv_4A2", pif.pixel_out, 12'hB5D);

        state = 2'b11;
        applyStimulus();
        applyStimulus();
        pif.valid_in = 1'b1; pif.pixel_in = 12'h888;
        applyStimulus();
        checkOutput("thr_888", pif.pixel_out, 12'hFFF);
        pif.pixel_in = 12'h111;
        applyStimulus();
        checkOutput("thr_111", pif.pixel_out, 12'h000);
        pif.valid_in = 1'b0;
        applyStimulus();

        // Filter switches on the same edge a pixel is taken: that pixel keeps threshold.
        state = 2'b00;
        applyStimulus();
        pif.valid_in = 1'b1; pif.pixel_in = 12'h4A2;
        applyStimulus();
        checkOutput("same_edge_old_filter", pif.pixel_out, 12'h000);
        checkOutput("same_edge_active", {10'd0, filter_active}, 12'd0);
        applyStimulus();
        checkOutput("next_pixel_new_filter", pif.pixel_out, 12'h4A2);
        pif.valid_in = 1'b0;
        applyStimulus();

        // Backpressure mid-stream in pass mode.
        delivered.delete();
        log_en = 1'b1;
        pif.valid_in = 1'b1; pif.pixel_in = 12'h123;
        applyStimulus();
        pif.pixel_in = 12'h456; pif.ready_out = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("held_pixel", pif.pixel_out, 12'h123);
        checkOutput("held_ready_in", {11'd0, pif.ready_in}, 12'd0);
        pif.ready_out = 1'b1;
        applyStimulus();
        pif.pixel_in = 12'h789;
        applyStimulus();
        pif.valid_in = 1'b0;
        applyStimulus();
        applyStimulus();
        log_en = 1'b0;
        checkOutput("stream_count", 12'(delivered.size()), 12'd3);
        if (delivered.size() == 3) begin
            checkOutput("stream_0", delivered[0], 12'h123);
            checkOutput("stream_1", delivered[1], 12'h456);
            checkOutput("stream_2", delivered[2], 12'h789);
        end

        // Reset while a request is pending and the output stage is full.
        state = 2'b10;
        pif.valid_in = 1'b1; pif.pixel_in = 12'hFFF;
        applyStimulus();
        pif.valid_in = 1'b0;
        checkOutput("pre_rst_valid", {11'd0, pif.valid_out}, 12'd1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("rst2_active", {10'd0, filter_active}, 12'd0);
        checkOutput("rst2_valid", {11'd0, pif.valid_out}, 12'd0);
        checkOutput("rst2_pixel", pif.pixel_out, 12'h000);
        reset = 1'b0;
        applyStimulus();
        checkOutput("pending_discarded", {10'd0, filter_active}, 12'd0);
        applyStimulus();
        checkOutput("recount_done", {10'd0, filter_active}, 12'd2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
